// File: rtl/cve2_pkg.sv
// Shared types for the two-host memory arbiter and its response pipeline.
package cve2_pkg;

    // Which host a tracked access belongs to.
    typedef enum logic {
        SrcInstr = 1'b0,
        SrcData  = 1'b1
    } mem_src_e;

    // One slot of the response-tracking pipeline.
    typedef struct packed {
        logic     valid;
        mem_src_e src;
        logic     err;
        logic     we;
    } mem_resp_t;

    localparam mem_resp_t MemRespIdle = '{valid: 1'b0, src: SrcInstr, err: 1'b0, we: 1'b0};

endpackage

// File: rtl/cve2_mem_resp_pipe.sv
// Fixed-depth shift register tracking accesses until their response cycle.
module cve2_mem_resp_pipe
    import cve2_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  mem_resp_t resp_i,
    output mem_resp_t resp_o
);

    mem_resp_t stage_q [Depth];
    mem_resp_t stage_d [Depth];

    // Every stage shifts one slot per cycle; stage 0 takes the new entry.
    always_comb begin
        stage_d[0] = resp_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stage_q[i] <= MemRespIdle;
            end
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign resp_o = stage_q[Depth-1];

endmodule

// File: rtl/cve2_mem_arbiter.sv
// Round-robin arbiter serving instruction and data hosts from one SRAM.
module cve2_mem_arbiter
    import cve2_pkg::*;
#(
    parameter logic [31:0] MemBaseAddr  = 32'h0000_0000,
    parameter int unsigned MemSizeBytes = 65536,
    parameter int unsigned RamLatency   = 1,
    localparam int unsigned AW          = $clog2(MemSizeBytes / 4)
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          instr_req_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    input  logic [31:0]   instr_addr_i,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,

    input  logic          data_req_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,

    output logic          ram_req_o,
    output logic          ram_we_o,
    output logic [3:0]    ram_be_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_wdata_o,
    input  logic [31:0]   ram_rdata_i
);

    localparam logic [31:0] MemSizeW = 32'(MemSizeBytes);

    logic        prio_instr_q, prio_instr_d;
    logic        instr_win, data_win, any_gnt;
    logic [31:0] sel_addr, offset;
    logic        in_range;
    mem_resp_t   resp_in, resp_out;

    // Arbitration: a lone requester always wins; on contention the flag decides.
    always_comb begin
        instr_win    = instr_req_i & (~data_req_i | prio_instr_q);
        data_win     = data_req_i & ~instr_win;
        any_gnt      = instr_win | data_win;
        prio_instr_d = prio_instr_q;
        if (instr_win) begin
            prio_instr_d = 1'b0;
        end else if (data_win) begin
            prio_instr_d = 1'b1;
        end
    end

    // Round-robin flag; data host has priority out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_instr_q <= 1'b0;
        end else begin
            prio_instr_q <= prio_instr_d;
        end
    end

    assign instr_gnt_o = instr_win;
    assign data_gnt_o  = data_win;

    // Range decode and RAM-side drive; below-base addresses wrap and miss.
    always_comb begin
        sel_addr    = instr_win ? instr_addr_i : data_addr_i;
        offset      = sel_addr - MemBaseAddr;
        in_range    = offset < MemSizeW;
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (any_gnt && in_range) begin
            ram_req_o  = 1'b1;
            ram_addr_o = offset[AW+1:2];
            if (data_win) begin
                ram_we_o    = data_we_i;
                ram_be_o    = data_be_i;
                ram_wdata_o = data_wdata_i;
            end else begin
                ram_be_o    = 4'hF;
            end
        end
    end

    // Entry recorded for every grant, including out-of-range ones.
    always_comb begin
        resp_in       = MemRespIdle;
        resp_in.valid = any_gnt;
        resp_in.src   = data_win ? SrcData : SrcInstr;
        resp_in.err   = any_gnt & ~in_range;
        resp_in.we    = data_win & data_we_i;
    end

    cve2_mem_resp_pipe #(
        .Depth (RamLatency)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .resp_i (resp_in),
        .resp_o (resp_out)
    );

    // Response demux: only the recorded host sees rvalid, data and error.
    always_comb begin
        instr_rvalid_o = 1'b0;
        instr_err_o    = 1'b0;
        instr_rdata_o  = '0;
        data_rvalid_o  = 1'b0;
        data_err_o     = 1'b0;
        data_rdata_o   = '0;
        if (resp_out.valid) begin
            if (resp_out.src == SrcInstr) begin
                instr_rvalid_o = 1'b1;
                instr_err_o    = resp_out.err;
                instr_rdata_o  = (resp_out.err || resp_out.we) ? '0 : ram_rdata_i;
            end else begin
                data_rvalid_o  = 1'b1;
                data_err_o     = resp_out.err;
                data_rdata_o   = (resp_out.err || resp_out.we) ? '0 : ram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Directed bench: default instance (latency 1) plus a latency-3, high-base instance.
module tb_cve2_mem_arbiter;

    typedef struct packed {
        logic        ignt, dgnt, rreq, rwe;
        logic [3:0]  rbe;
        logic [13:0] raddr;
        logic [31:0] rwdata;
        logic        irv, ierr;
        logic [31:0] irdata;
        logic        drv, derr;
        logic [31:0] drdata;
    } out_t;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq, dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr, dwdata;
        out_t        exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- instance A: defaults ----------------
    logic        rst_a = 1'b1;
    logic        ia_req = 0, da_req = 0, da_we = 0;
    logic [31:0] ia_addr = '0, da_addr = '0, da_wdata = '0;
    logic [3:0]  da_be = '0;
    logic        ia_gnt, ia_rv, ia_err, da_gnt, da_rv, da_err;
    logic [31:0] ia_rdata, da_rdata;
    logic        ra_req, ra_we;
    logic [3:0]  ra_be;
    logic [13:0] ra_addr;
    logic [31:0] ra_wdata, ra_rdata;

    cve2_mem_arbiter dut_a (
        .clk_i(clk), .rst_i(rst_a),
        .instr_req_i(ia_req), .instr_gnt_o(ia_gnt), .instr_rvalid_o(ia_rv),
        .instr_addr_i(ia_addr), .instr_rdata_o(ia_rdata), .instr_err_o(ia_err),
        .data_req_i(da_req), .data_gnt_o(da_gnt), .data_rvalid_o(da_rv),
        .data_we_i(da_we), .data_be_i(da_be), .data_addr_i(da_addr),
        .data_wdata_i(da_wdata), .data_rdata_o(da_rdata), .data_err_o(da_err),
        .ram_req_o(ra_req), .ram_we_o(ra_we), .ram_be_o(ra_be),
        .ram_addr_o(ra_addr), .ram_wdata_o(ra_wdata), .ram_rdata_i(ra_rdata)
    );

    logic [31:0] mem_a [16384];
    initial begin
        for (int i = 0; i < 16384; i++) mem_a[i] = '0;
        ra_rdata = '0;
    end
    always @(posedge clk) begin
        if (ra_req) begin
            if (ra_we) begin
                for (int b = 0; b < 4; b++)
                    if (ra_be[b]) mem_a[ra_addr][b*8 +: 8] <= ra_wdata[b*8 +: 8];
            end else begin
                ra_rdata <= mem_a[ra_addr];
            end
        end
    end

    out_t act_a;
    assign act_a = {ia_gnt, da_gnt, ra_req, ra_we, ra_be, ra_addr, ra_wdata,
                    ia_rv, ia_err, ia_rdata, da_rv, da_err, da_rdata};

    // ---------------- instance B: base 0x8000_0000, 256 B, latency 3 ----------------
    logic        rst_b = 1'b1;
    logic        ib_req = 0, db_req = 0, db_we = 0;
    logic [31:0] ib_addr = '0, db_addr = '0, db_wdata = '0;
    logic [3:0]  db_be = '0;
    logic        ib_gnt, ib_rv, ib_err, db_gnt, db_rv, db_err;
    logic [31:0] ib_rdata, db_rdata;
    logic        rb_req, rb_we;
    logic [3:0]  rb_be;
    logic [5:0]  rb_addr;
    logic [31:0] rb_wdata;
    logic [31:0] rb_pipe [3];

    cve2_mem_arbiter #(
        .MemBaseAddr(32'h8000_0000), .MemSizeBytes(256), .RamLatency(3)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_b),
        .instr_req_i(ib_req), .instr_gnt_o(ib_gnt), .instr_rvalid_o(ib_rv),
        .instr_addr_i(ib_addr), .instr_rdata_o(ib_rdata), .instr_err_o(ib_err),
        .data_req_i(db_req), .data_gnt_o(db_gnt), .data_rvalid_o(db_rv),
        .data_we_i(db_we), .data_be_i(db_be), .data_addr_i(db_addr),
        .data_wdata_i(db_wdata), .data_rdata_o(db_rdata), .data_err_o(db_err),
        .ram_req_o(rb_req), .ram_we_o(rb_we), .ram_be_o(rb_be),
        .ram_addr_o(rb_addr), .ram_wdata_o(rb_wdata), .ram_rdata_i(rb_pipe[2])
    );

    logic [31:0] mem_b [64];
    initial begin
        for (int i = 0; i < 64; i++) mem_b[i] = 32'(i) * 32'h0101_0101;
        for (int i = 0; i < 3; i++) rb_pipe[i] = '0;
    end
    always @(posedge clk) begin
        rb_pipe[0] <= (rb_req && !rb_we) ? mem_b[rb_addr] : 32'h0;
        rb_pipe[1] <= rb_pipe[0];
        rb_pipe[2] <= rb_pipe[1];
    end

    out_t act_b;
    assign act_b = {ib_gnt, db_gnt, rb_req, rb_we, rb_be, 8'h00, rb_addr, rb_wdata,
                    ib_rv, ib_err, ib_rdata, db_rv, db_err, db_rdata};

    // ---------------- helpers ----------------
    function automatic out_t O(input logic ig, input logic dg, input logic rq, input logic rw,
                               input logic [3:0] rb, input logic [13:0] ra, input logic [31:0] rwd,
                               input logic irv, input logic ie, input logic [31:0] ird,
                               input logic drv, input logic de, input logic [31:0] drd);
        return {ig, dg, rq, rw, rb, ra, rwd, irv, ie, ird, drv, de, drd};
    endfunction

    function automatic vec_t V(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic dwe, input logic [3:0] dbe,
                               input logic [31:0] daddr, input logic [31:0] dwd, input out_t e);
        vec_t v;
        v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
        v.dbe = dbe; v.daddr = daddr; v.dwdata = dwd; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input out_t act, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_b(input logic ireq, input logic [31:0] iaddr,
                           input logic dreq, input logic [31:0] daddr);
        @(posedge clk);
        #1;
        ib_req = ireq; ib_addr = iaddr;
        db_req = dreq; db_addr = daddr; db_we = 1'b0; db_be = 4'hF; db_wdata = '0;
    endtask

    vec_t tbl [17];
    out_t Z;

    initial begin
        Z = '0;
        tbl[0]  = V(0, 32'h0,     1, 1, 4'hF, 32'h10, 32'h1234_5678, O(0,1,1,1,4'hF,14'h4,32'h1234_5678, 0,0,32'h0, 0,0,32'h0));
        tbl[1]  = V(0, 32'h0,     1, 0, 4'hF, 32'h10, 32'h0,         O(0,1,1,0,4'hF,14'h4,32'h0, 0,0,32'h0, 1,0,32'h0));
        tbl[2]  = V(0, 32'h0,     0, 0, 4'h0, 32'h0,  32'h0,         O(0,0,0,0,4'h0,14'h0,32'h0, 0,0,32'h0, 1,0,32'h1234_5678));
        tbl[3]  = V(0, 32'h0,     1, 1, 4'h3, 32'h20, 32'hDEAD_BEEF, O(0,1,1,1,4'h3,14'h8,32'hDEAD_BEEF, 0,0,32'h0, 0,0,32'h0));
        tbl[4]  = V(0, 32'h0,     1, 0, 4'hF, 32'h20, 32'h0,         O(0,1,1,0,4'hF,14'h8,32'h0, 0,0,32'h0, 1,0,32'h0));
        tbl[5]  = V(0, 32'h0,     0, 0, 4'h0, 32'h0,  32'h0,         O(0,0,0,0,4'h0,14'h0,32'h0, 0,0,32'h0, 1,0,32'h0000_BEEF));
        tbl[6]  = V(1, 32'h10,    0, 0, 4'h0, 32'h0,  32'h0,         O(1,0,1,0,4'hF,14'h4,32'h0, 0,0,32'h0, 0,0,32'h0));
        tbl[7]  = V(1, 32'h20,    1, 0, 4'hF, 32'h10, 32'h0,         O(0,1,1,0,4'hF,14'h4,32'h0, 1,0,32'h1234_5678, 0,0,32'h0));
        tbl[8]  = V(1, 32'h20,    1, 0, 4'hF, 32'h10, 32'h0,         O(1,0,1,0,4'hF,14'h8,32'h0, 0,0,32'h0, 1,0,32'h1234_5678));
        tbl[9]  = V(1, 32'h20,    1, 0, 4'hF, 32'h10, 32'h0,         O(0,1,1,0,4'hF,14'h4,32'h0, 1,0,32'h0000_BEEF, 0,0,32'h0));
        tbl[10] = V(1, 32'h20,    1, 0, 4'hF, 32'h10, 32'h0,         O(1,0,1,0,4'hF,14'h8,32'h0, 0,0,32'h0, 1,0,32'h1234_5678));
        tbl[11] = V(0, 32'h0,     0, 0, 4'h0, 32'h0,  32'h0,         O(0,0,0,0,4'h0,14'h0,32'h0, 1,0,32'h0000_BEEF, 0,0,32'h0));
        tbl[12] = V(0, 32'h0,     1, 1, 4'hF, 32'hFFFC, 32'hCAFE_F00D, O(0,1,1,1,4'hF,14'h3FFF,32'hCAFE_F00D, 0,0,32'h0, 0,0,32'h0));
        tbl[13] = V(1, 32'h1_0000, 0, 0, 4'h0, 32'h0, 32'h0,         O(1,0,0,0,4'h0,14'h0,32'h0, 0,0,32'h0, 1,0,32'h0));
        tbl[14] = V(1, 32'hFFFC,  0, 0, 4'h0, 32'h0,  32'h0,         O(1,0,1,0,4'hF,14'h3FFF,32'h0, 1,1,32'h0, 0,0,32'h0));
        tbl[15] = V(0, 32'h0,     1, 0, 4'hF, 32'hFFFF_FFF0, 32'h0,  O(0,1,0,0,4'h0,14'h0,32'h0, 1,0,32'hCAFE_F00D, 0,0,32'h0));
        tbl[16] = V(0, 32'h0,     0, 0, 4'h0, 32'h0,  32'h0,         O(0,0,0,0,4'h0,14'h0,32'h0, 0,0,32'h0, 1,1,32'h0));

        // ---- instance A: reset state then the vector table ----
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        @(negedge clk);
        chk("a_reset", act_a, Z);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            ia_req = tbl[i].ireq; ia_addr = tbl[i].iaddr;
            da_req = tbl[i].dreq; da_we = tbl[i].dwe; da_be = tbl[i].dbe;
            da_addr = tbl[i].daddr; da_wdata = tbl[i].dwdata;
            @(negedge clk);
            chk($sformatf("a_vec%0d", i), act_a, tbl[i].exp);
        end

        // ---- instance B: wrap-around error and last-word read at latency 3 ----
        @(posedge clk);
        #1 rst_b = 1'b0;
        @(negedge clk);
        chk("b_reset", act_b, Z);
        drive_b(0, 32'h0, 1, 32'h7FFF_FFFC);
        @(negedge clk);
        chk("b_wrap_gnt", act_b, O(0,1,0,0,4'h0,14'h0,32'h0, 0,0,32'h0, 0,0,32'h0));
        drive_b(1, 32'h8000_00FC, 0, 32'h0);
        @(negedge clk);
        chk("b_last_gnt", act_b, O(1,0,1,0,4'hF,14'd63,32'h0, 0,0,32'h0, 0,0,32'h0));
        drive_b(0, 32'h0, 0, 32'h0);
        @(negedge clk);
        chk("b_wait", act_b, Z);
        drive_b(0, 32'h0, 0, 32'h0);
        @(negedge clk);
        chk("b_wrap_err", act_b, O(0,0,0,0,4'h0,14'h0,32'h0, 0,0,32'h0, 1,1,32'h0));
        drive_b(0, 32'h0, 0, 32'h0);
        @(negedge clk);
        chk("b_last_data", act_b, O(0,0,0,0,4'h0,14'h0,32'h0, 1,0,32'h3F3F_3F3F, 0,0,32'h0));
        drive_b(0, 32'h0, 0, 32'h0);
        @(negedge clk);
        chk("b_quiet", act_b, Z);

        // ---- instance B: three fetches in flight, then reset ----
        for (int k = 0; k < 3; k++) begin
            drive_b(1, 32'h8000_0000 + 32'(k * 4), 0, 32'h0);
            @(negedge clk);
            chk($sformatf("b_fetch%0d", k), act_b, O(1,0,1,0,4'hF,14'(k),32'h0, 0,0,32'h0, 0,0,32'h0));
        end
        @(posedge clk);
        #1;
        ib_req = 1'b0; ib_addr = '0;
        rst_b = 1'b1;
        @(negedge clk);
        chk("b_in_reset", act_b, Z);
        @(posedge clk);
        #1 rst_b = 1'b0;
        @(negedge clk);
        chk("b_post_reset0", act_b, Z);
        for (int k = 1; k < 5; k++) begin
            drive_b(0, 32'h0, 0, 32'h0);
            @(negedge clk);
            chk($sformatf("b_post_reset%0d", k), act_b, Z);
        end
        drive_b(1, 32'h8000_0008, 0, 32'h0);
        @(negedge clk);
        chk("b_refetch_gnt", act_b, O(1,0,1,0,4'hF,14'd2,32'h0, 0,0,32'h0, 0,0,32'h0));
        for (int k = 0; k < 2; k++) begin
            drive_b(0, 32'h0, 0, 32'h0);
            @(negedge clk);
            chk($sformatf("b_refetch_wait%0d", k), act_b, Z);
        end
        drive_b(0, 32'h0, 0, 32'h0);
        @(negedge clk);
        chk("b_refetch_data", act_b, O(0,0,0,0,4'h0,14'h0,32'h0, 1,0,32'h0202_0202, 0,0,32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
